// File: rtl/mbist_pkg.sv
// Shared types and constants for the MBIST memory-side responder.
// Optional hit counter is enabled by defining MBIST_MEM_HIT_CNT_EN.
package mbist_pkg;

    localparam logic [1:0] BANK0 = 2'b01;
    localparam logic [1:0] BANK1 = 2'b10;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;

    typedef struct packed {
        logic              valid;
        logic              bank;
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] val;
    } flt_entry_t;

    typedef enum logic {
        CLR,
        RUN
    } state_t;

    function automatic logic bank_legal(input logic [1:0] b);
        return (b == BANK0) || (b == BANK1);
    endfunction

endpackage

// File: rtl/mbist_fault_table.sv
// Stuck-at fault table: sequenced invalidation, programming and
// combinational match/apply of one raw byte.
module mbist_fault_table
    import mbist_pkg::*;
#(
    parameter int ROW_W      = 9,
    parameter int COL_W      = 9,
    parameter int NUM_FAULTS = 4,
    parameter int IDX_W      = $clog2(NUM_FAULTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inv,
    input  logic [IDX_W-1:0]  i_inv_idx,
    input  logic              i_wr,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  flt_entry_t        i_wr_entry,
    input  logic              i_bank,
    input  logic [ADDR_W-1:0] i_row,
    input  logic [ADDR_W-1:0] i_col,
    input  logic [DATA_W-1:0] i_raw,
    output logic [DATA_W-1:0] o_data,
    output logic              o_hit
);

    localparam logic [ADDR_W-1:0] ROW_MSK = ADDR_W'((1 << ROW_W) - 1);
    localparam logic [ADDR_W-1:0] COL_MSK = ADDR_W'((1 << COL_W) - 1);

    flt_entry_t        r_tab [NUM_FAULTS];
    logic [DATA_W-1:0] w_data;
    logic              w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                r_tab[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (i_inv && i_inv_idx == IDX_W'(i)) begin
                    r_tab[i].valid <= 1'b0;
                end else if (i_wr && i_wr_idx == IDX_W'(i)) begin
                    r_tab[i] <= i_wr_entry;
                end
            end
        end
    end

    // Ascending walk: a higher index overrides shared stuck bits.
    always_comb begin
        w_data = i_raw;
        w_hit  = 1'b0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (r_tab[i].valid &&
                r_tab[i].bank == i_bank &&
                ((r_tab[i].row ^ i_row) & ROW_MSK) == '0 &&
                ((r_tab[i].col ^ i_col) & COL_MSK) == '0) begin
                w_data = (w_data & ~r_tab[i].mask) |
                         (r_tab[i].val & r_tab[i].mask);
                w_hit  = 1'b1;
            end
        end
    end

    assign o_data = w_data;
    assign o_hit  = w_hit;

endmodule

// File: rtl/mbist_mem_model.sv
// Memory-side responder for the MBIST controller with stuck-at faults.
// Define MBIST_MEM_HIT_CNT_EN to enable the fault-hit read counter.
module mbist_mem_model
    import mbist_pkg::*;
#(
    parameter int ROW_W      = 9,
    parameter int COL_W      = 9,
    parameter int NUM_FAULTS = 4,
    parameter int READ_LAT   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ce,
    input  logic                          we,
    input  logic [9:0]                    row_addr,
    input  logic [9:0]                    col_addr,
    input  logic [1:0]                    bank_addr,
    input  logic [7:0]                    data_w,
    output logic [7:0]                    data_r,
    output logic                          addr_err,
    output logic                          ready,
    input  logic                          flt_wr,
    input  logic                          flt_clr,
    input  logic [$clog2(NUM_FAULTS)-1:0] flt_idx,
    input  logic                          flt_bank,
    input  logic [ROW_W-1:0]              flt_row,
    input  logic [COL_W-1:0]              flt_col,
    input  logic [7:0]                    flt_mask,
    input  logic [7:0]                    flt_val,
    output logic [15:0]                   hit_cnt
);

    localparam int IDX_W = $clog2(NUM_FAULTS);
    localparam int MEM_D = 2 ** (ROW_W + COL_W + 1);

    state_t                  r_state;
    state_t                  w_nxt_state;
    logic [IDX_W-1:0]        r_clr_idx;
    logic                    r_addr_err;
    logic [DATA_W-1:0]       r_mem [MEM_D];

    logic                    w_run;
    logic                    w_legal;
    logic                    w_bank_sel;
    logic                    w_rd;
    logic                    w_wr;
    logic                    w_clr_last;
    logic [ROW_W+COL_W:0]    w_idx;
    logic [DATA_W-1:0]       w_fix;
    logic                    w_hit;
    logic [DATA_W-1:0]       w_rd_data;
    flt_entry_t              w_new_entry;

    assign w_run      = (r_state == RUN);
    assign w_legal    = bank_legal(bank_addr);
    assign w_bank_sel = bank_addr[1];
    assign w_rd       = w_run & ce & ~we;
    assign w_wr       = w_run & ce & we & w_legal;
    assign w_clr_last = (r_state == CLR) &&
                        (r_clr_idx == IDX_W'(NUM_FAULTS - 1));
    assign w_idx      = {w_bank_sel, row_addr[ROW_W-1:0],
                         col_addr[COL_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLR;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        unique case (r_state)
            CLR: if (w_clr_last) w_nxt_state = RUN;
            RUN: if (flt_clr) w_nxt_state = CLR;
            default: w_nxt_state = CLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_idx <= '0;
        end else if (r_state == CLR) begin
            r_clr_idx <= w_clr_last ? '0 : r_clr_idx + 1'b1;
        end else if (flt_clr) begin
            r_clr_idx <= '0;
        end
    end

    always_comb begin
        w_new_entry       = '0;
        w_new_entry.valid = 1'b1;
        w_new_entry.bank  = flt_bank;
        w_new_entry.row   = ADDR_W'(flt_row);
        w_new_entry.col   = ADDR_W'(flt_col);
        w_new_entry.mask  = flt_mask;
        w_new_entry.val   = flt_val;
    end

    mbist_fault_table #(
        .ROW_W      (ROW_W),
        .COL_W      (COL_W),
        .NUM_FAULTS (NUM_FAULTS),
        .IDX_W      (IDX_W)
    ) u_ftab (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inv      (r_state == CLR),
        .i_inv_idx  (r_clr_idx),
        .i_wr       (w_run & flt_wr & ~flt_clr),
        .i_wr_idx   (flt_idx),
        .i_wr_entry (w_new_entry),
        .i_bank     (w_bank_sel),
        .i_row      (row_addr),
        .i_col      (col_addr),
        .i_raw      (r_mem[w_idx]),
        .o_data     (w_fix),
        .o_hit      (w_hit)
    );

    // Storage is deliberately never reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= data_w;
        end
    end

    assign w_rd_data = (w_rd && w_legal) ? w_fix : '0;

    generate
        if (READ_LAT == 0) begin : g_lat0
            assign data_r = w_rd_data;
        end else begin : g_lat1
            logic [DATA_W-1:0] r_data;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (w_rd) begin
                    r_data <= w_rd_data;
                end
            end
            assign data_r = r_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_run & ce & ~w_legal;
        end
    end

    assign addr_err = r_addr_err;
    assign ready    = w_run;

`ifdef MBIST_MEM_HIT_CNT_EN
    logic [15:0] r_hit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt <= '0;
        end else if (w_run && flt_clr) begin
            r_hit_cnt <= '0;
        end else if (w_rd && w_legal && w_hit &&
                     r_hit_cnt != 16'hFFFF) begin
            r_hit_cnt <= r_hit_cnt + 16'd1;
        end
    end

    assign hit_cnt = r_hit_cnt;
`else
    // Hit flag has no consumer here; masking keeps the output at zero.
    assign hit_cnt = {15'd0, w_hit & 1'b0};
`endif

endmodule
